// File: rtl/decoder_10b8b_rx.sv
// decoder_10b8b_rx
//   Receive-side 10b/8b decoder with running-disparity tracking, code and
//   disparity error flags, and a comma-based word-sync state machine.
//   One registered output stage; one group accepted per cycle.
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   rx_valid, rx_code input code group, [9:4]=abcdei, [3:0]=fghj
//   dec_valid         registered decode valid
//   dec_data, dec_k   decoded byte {HGF,EDCBA} and K-symbol flag
//   comma_det         K28.1 / K28.5 / K28.7 seen
//   code_err          group not in either RD column of the code table
//   disp_err          legal group arriving at the wrong running disparity
//   rd_out            running disparity after the group (1 = positive)
//   sync_ok           word-sync FSM is in SYNC
module decoder_10b8b_rx #(
    parameter int LOCK_COMMAS = 3,
    parameter int LOSS_ERRS   = 4,
    parameter int GOOD_RUN    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_valid,
    input  logic [9:0] rx_code,
    output logic       dec_valid,
    output logic [7:0] dec_data,
    output logic       dec_k,
    output logic       comma_det,
    output logic       code_err,
    output logic       disp_err,
    output logic       rd_out,
    output logic       sync_ok
);

    typedef struct packed {
        logic       ok;
        logic       k;
        logic [2:0] y;
    } dec4_t;

    typedef enum logic [1:0] {LOS, ACQ, SYNC} state_t;

    // 4b decode for a given RD at the 4b boundary (mid=1 positive).
    // Weight-1 patterns and 0011 are the RD+ forms; folding them onto the
    // RD- form leaves a single lookup. The alternate x.7 form is legal only
    // after D11/13/14 at RD+ or D17/18/20 at RD-, where the primary form is
    // then illegal; after D23/27/29/30 it is the K.x.7 symbol.
    function automatic dec4_t dec4(input logic mid, input logic [4:0] x,
                                   input logic [3:0] f);
        dec4_t      r;
        logic [3:0] n;
        logic [2:0] ones;
        logic       col_ok, a7_ok, kx;
        r      = '0;
        ones   = 3'($countones(f));
        n      = (ones == 3'd1 || f == 4'b0011) ? ~f : f;
        col_ok = mid ? (ones <= 3'd2 && f != 4'b1100)
                     : (ones >= 3'd2 && f != 4'b0011);
        a7_ok  = mid ? (x == 5'd11 || x == 5'd13 || x == 5'd14)
                     : (x == 5'd17 || x == 5'd18 || x == 5'd20);
        kx     = (x == 5'd23 || x == 5'd27 || x == 5'd29 || x == 5'd30);
        case (n)
            4'b1011: begin r.ok = 1'b1; r.y = 3'd0; end
            4'b1001: begin r.ok = 1'b1; r.y = 3'd1; end
            4'b0101: begin r.ok = 1'b1; r.y = 3'd2; end
            4'b1100: begin r.ok = 1'b1; r.y = 3'd3; end
            4'b1101: begin r.ok = 1'b1; r.y = 3'd4; end
            4'b1010: begin r.ok = 1'b1; r.y = 3'd5; end
            4'b0110: begin r.ok = 1'b1; r.y = 3'd6; end
            4'b1110: begin r.ok = !a7_ok; r.y = 3'd7; end
            4'b0111: begin r.ok = a7_ok || kx; r.k = kx; r.y = 3'd7; end
            default: ;
        endcase
        r.ok = r.ok && col_ok;
        return r;
    endfunction

    logic [5:0] s6, n6;
    logic [3:0] f4, k4, ones10;
    logic [2:0] ones6, ones4, ky;
    logic [4:0] x;
    logic       v6, k28, kok, can_n, can_p, mid_n, mid_p;
    dec4_t      rn, rp, sel;
    logic       valid_c, k_c, comma_c, disp_c, rd6, rd_nxt, err;
    logic [7:0] data_c;

    state_t     state, state_nxt;
    logic [3:0] comma_cnt, comma_cnt_nxt, err_cnt, err_cnt_nxt;
    logic [3:0] good_cnt, good_cnt_nxt;

    assign s6    = rx_code[9:4];
    assign f4    = rx_code[3:0];
    assign ones6 = 3'($countones(s6));
    assign ones4 = 3'($countones(f4));

    // 6b lookup on the RD- form; weight-2 blocks and 000111 are RD+ forms
    // and are complemented first (111100/000011 fall to default).
    always_comb begin
        n6  = (ones6 == 3'd2 || s6 == 6'b000111) ? ~s6 : s6;
        v6  = 1'b1;
        k28 = 1'b0;
        x   = 5'd0;
        case (n6)
            6'b100111: x = 5'd0;   6'b011101: x = 5'd1;
            6'b101101: x = 5'd2;   6'b110001: x = 5'd3;
            6'b110101: x = 5'd4;   6'b101001: x = 5'd5;
            6'b011001: x = 5'd6;   6'b111000: x = 5'd7;
            6'b111001: x = 5'd8;   6'b100101: x = 5'd9;
            6'b010101: x = 5'd10;  6'b110100: x = 5'd11;
            6'b001101: x = 5'd12;  6'b101100: x = 5'd13;
            6'b011100: x = 5'd14;  6'b010111: x = 5'd15;
            6'b011011: x = 5'd16;  6'b100011: x = 5'd17;
            6'b010011: x = 5'd18;  6'b110010: x = 5'd19;
            6'b001011: x = 5'd20;  6'b101010: x = 5'd21;
            6'b011010: x = 5'd22;  6'b111010: x = 5'd23;
            6'b110011: x = 5'd24;  6'b100110: x = 5'd25;
            6'b010110: x = 5'd26;  6'b110110: x = 5'd27;
            6'b001110: x = 5'd28;  6'b101110: x = 5'd29;
            6'b011110: x = 5'd30;  6'b101011: x = 5'd31;
            6'b001111: begin x = 5'd28; k28 = 1'b1; end
            default:   v6 = 1'b0;
        endcase
    end

    // K28.y: 4b folded to the form that follows 110000.
    always_comb begin
        k4  = (ones6 == 3'd4) ? ~f4 : f4;
        kok = 1'b1;
        ky  = 3'd0;
        case (k4)
            4'b1011: ky = 3'd0;  4'b0110: ky = 3'd1;
            4'b1010: ky = 3'd2;  4'b1100: ky = 3'd3;
            4'b1101: ky = 3'd4;  4'b0101: ky = 3'd5;
            4'b1001: ky = 3'd6;  4'b0111: ky = 3'd7;
            default: kok = 1'b0;
        endcase
    end

    always_comb begin
        // A balanced 6b block is legal in both RD columns, so its 4b block
        // is tried against both possible mid-group disparities.
        can_n   = v6 && !k28 && ones6 >= 3'd3 && s6 != 6'b000111;
        can_p   = v6 && !k28 && ones6 <= 3'd3 && s6 != 6'b111000;
        mid_n   = (ones6 == 3'd4);
        mid_p   = (ones6 != 3'd2);
        rn      = dec4(mid_n, x, f4);
        rp      = dec4(mid_p, x, f4);
        sel     = (can_n && rn.ok) ? rn : rp;
        valid_c = k28 ? kok : ((can_n && rn.ok) || (can_p && rp.ok));
        data_c  = k28 ? {ky, 5'd28} : {sel.y, x};
        k_c     = k28 | sel.k;
        comma_c = k28 && (ky == 3'd1 || ky == 3'd5 || ky == 3'd7);
        if (!valid_c) begin
            data_c  = 8'h00;
            k_c     = 1'b0;
            comma_c = 1'b0;
        end

        // Unbalanced blocks must oppose the incoming RD; 000111/0011 are
        // the RD+ forms and 111000/1100 the RD- forms, so those four must
        // match the incoming RD.
        disp_c = (ones6 > 3'd3 && rd_out) || (ones6 < 3'd3 && !rd_out) ||
                 (s6 == 6'b000111 && !rd_out) || (s6 == 6'b111000 && rd_out);
        rd6    = (ones6 > 3'd3 || s6 == 6'b000111) ? 1'b1 :
                 (ones6 < 3'd3 || s6 == 6'b111000) ? 1'b0 : rd_out;
        disp_c = disp_c || (ones4 > 3'd2 && rd6) || (ones4 < 3'd2 && !rd6) ||
                 (f4 == 4'b0011 && !rd6) || (f4 == 4'b1100 && rd6);
        rd_nxt = (ones4 > 3'd2 || f4 == 4'b0011) ? 1'b1 :
                 (ones4 < 3'd2 || f4 == 4'b1100) ? 1'b0 : rd6;

        ones10 = 4'(ones6) + 4'(ones4);
        if (!valid_c) begin
            disp_c = 1'b0;
            rd_nxt = (ones10 > 4'd5) ? 1'b1 : (ones10 < 4'd5) ? 1'b0 : rd_out;
        end
        err = !valid_c || disp_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= LOS;
            comma_cnt <= 4'd0;
            err_cnt   <= 4'd0;
            good_cnt  <= 4'd0;
        end else begin
            state     <= state_nxt;
            comma_cnt <= comma_cnt_nxt;
            err_cnt   <= err_cnt_nxt;
            good_cnt  <= good_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        comma_cnt_nxt = comma_cnt;
        err_cnt_nxt   = err_cnt;
        good_cnt_nxt  = good_cnt;
        if (rx_valid) begin
            case (state)
                LOS: if (comma_c && !err) begin
                    if (LOCK_COMMAS <= 1) begin
                        state_nxt    = SYNC;
                        err_cnt_nxt  = 4'd0;
                        good_cnt_nxt = 4'd0;
                    end else begin
                        state_nxt     = ACQ;
                        comma_cnt_nxt = 4'd1;
                    end
                end
                ACQ: if (err) begin
                    state_nxt     = LOS;
                    comma_cnt_nxt = 4'd0;
                end else if (comma_c) begin
                    if (int'(comma_cnt) + 1 >= LOCK_COMMAS) begin
                        state_nxt     = SYNC;
                        comma_cnt_nxt = 4'd0;
                        err_cnt_nxt   = 4'd0;
                        good_cnt_nxt  = 4'd0;
                    end else begin
                        comma_cnt_nxt = comma_cnt + 4'd1;
                    end
                end
                SYNC: if (err) begin
                    good_cnt_nxt = 4'd0;
                    if (int'(err_cnt) + 1 >= LOSS_ERRS) begin
                        state_nxt   = LOS;
                        err_cnt_nxt = 4'd0;
                    end else begin
                        err_cnt_nxt = err_cnt + 4'd1;
                    end
                end else if (int'(good_cnt) + 1 >= GOOD_RUN) begin
                    good_cnt_nxt = 4'd0;
                    err_cnt_nxt  = (err_cnt != 4'd0) ? err_cnt - 4'd1 : 4'd0;
                end else begin
                    good_cnt_nxt = good_cnt + 4'd1;
                end
                default: state_nxt = LOS;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dec_valid <= 1'b0;
            dec_data  <= 8'h00;
            dec_k     <= 1'b0;
            comma_det <= 1'b0;
            code_err  <= 1'b0;
            disp_err  <= 1'b0;
            rd_out    <= 1'b0;
            sync_ok   <= 1'b0;
        end else if (rx_valid) begin
            dec_valid <= 1'b1;
            dec_data  <= data_c;
            dec_k     <= k_c;
            comma_det <= comma_c;
            code_err  <= !valid_c;
            disp_err  <= disp_c;
            rd_out    <= rd_nxt;
            sync_ok   <= (state_nxt == SYNC);
        end else begin
            dec_valid <= 1'b0;
            comma_det <= 1'b0;
            code_err  <= 1'b0;
            disp_err  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decoder_10b8b_rx.sv
// tb_decoder_10b8b_rx
//   Directed vectors for decoder_10b8b_rx with hand-computed expectations:
//   reset values, K/D decode, RD tracking, A7 legality, error handling,
//   output hold on idle cycles, and word-sync acquire/loss behaviour.
module tb_decoder_10b8b_rx;

    logic       clk = 1'b0;
    logic       rst, rx_valid;
    logic [9:0] rx_code;
    logic       dec_valid, dec_k, comma_det, code_err, disp_err, rd_out, sync_ok;
    logic [7:0] dec_data;

    int n_chk = 0;
    int n_err = 0;

    decoder_10b8b_rx dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_code(rx_code),
        .dec_valid(dec_valid), .dec_data(dec_data), .dec_k(dec_k),
        .comma_det(comma_det), .code_err(code_err), .disp_err(disp_err),
        .rd_out(rd_out), .sync_ok(sync_ok)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [9:0] c);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_code  = c;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        rx_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_dec(input string tag, input logic [7:0] d, input logic k,
                           input logic cm, input logic ce, input logic de, input logic rd);
        check({tag, ".valid"}, dec_valid, 1'b1);
        check({tag, ".data"},  dec_data,  d);
        check({tag, ".k"},     dec_k,     k);
        check({tag, ".comma"}, comma_det, cm);
        check({tag, ".cerr"},  code_err,  ce);
        check({tag, ".derr"},  disp_err,  de);
        check({tag, ".rd"},    rd_out,    rd);
    endtask

    task automatic chk_reset(input string tag);
        check({tag, ".valid"}, dec_valid, 1'b0);
        check({tag, ".data"},  dec_data,  8'h00);
        check({tag, ".k"},     dec_k,     1'b0);
        check({tag, ".comma"}, comma_det, 1'b0);
        check({tag, ".cerr"},  code_err,  1'b0);
        check({tag, ".derr"},  disp_err,  1'b0);
        check({tag, ".rd"},    rd_out,    1'b0);
        check({tag, ".sync"},  sync_ok,   1'b0);
    endtask

    // Reset with a valid comma presented; it must be ignored.
    task automatic do_reset(input string tag);
        @(negedge clk);
        rst      = 1'b1;
        rx_valid = 1'b1;
        rx_code  = 10'h0FA;
        @(posedge clk);
        #1;
        chk_reset(tag);
        @(negedge clk);
        rst      = 1'b0;
        rx_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_code  = 10'h000;
        repeat (2) @(posedge clk);
        do_reset("rst0");

        // Lock: K28.5 RD-, K28.5 RD+, K28.5 RD-
        send(10'h0FA);
        chk_dec("k285n", 8'hBC, 1, 1, 0, 0, 1);
        check("lock1.sync", sync_ok, 1'b0);
        send(10'h305);
        chk_dec("k285p", 8'hBC, 1, 1, 0, 0, 0);
        check("lock2.sync", sync_ok, 1'b0);
        send(10'h0FA);
        check("lock3.rd", rd_out, 1'b1);
        check("lock3.sync", sync_ok, 1'b1);

        // Idle cycle: strobes drop, data/k/rd/sync hold
        idle();
        check("idle.valid", dec_valid, 1'b0);
        check("idle.comma", comma_det, 1'b0);
        check("idle.data",  dec_data,  8'hBC);
        check("idle.k",     dec_k,     1'b1);
        check("idle.rd",    rd_out,    1'b1);
        check("idle.sync",  sync_ok,   1'b1);

        // 3 errors, 4 clean groups (err_cnt 3 -> 2), 1 error (-> 3), 1 more -> LOS
        send(10'h000);
        chk_dec("cerr", 8'h00, 0, 0, 1, 0, 0);
        check("e1.sync", sync_ok, 1'b1);
        for (int i = 0; i < 2; i++) begin
            send(10'h000);
            check("e23.sync", sync_ok, 1'b1);
        end
        for (int i = 0; i < 4; i++) begin
            send(10'h2AA);
            chk_dec("clean", 8'hB5, 0, 0, 0, 0, 0);
            check("clean.sync", sync_ok, 1'b1);
        end
        send(10'h000);
        check("e4.sync", sync_ok, 1'b1);
        send(10'h000);
        check("e5.sync", sync_ok, 1'b0);

        // Relock, then four consecutive errors
        send(10'h0FA);
        send(10'h305);
        send(10'h0FA);
        check("relock.sync", sync_ok, 1'b1);
        for (int i = 0; i < 4; i++) begin
            send(10'h000);
            check($sformatf("burst%0d.sync", i), sync_ok, (i == 3) ? 1'b0 : 1'b1);
        end

        // Data and K decode table spot checks
        do_reset("rst1");
        send(10'h274);
        chk_dec("d0_0", 8'h00, 0, 0, 0, 0, 0);
        send(10'h2AA);
        chk_dec("d21_5", 8'hB5, 0, 0, 0, 0, 0);
        send(10'h0F9);
        chk_dec("k28_1", 8'h3C, 1, 1, 0, 0, 1);
        send(10'h305);
        chk_dec("k28_5p", 8'hBC, 1, 1, 0, 0, 0);
        send(10'h0F8);
        chk_dec("k28_7", 8'hFC, 1, 1, 0, 0, 0);
        check("k28_7.sync", sync_ok, 1'b1);
        send(10'h3A8);
        chk_dec("k23_7", 8'hF7, 1, 0, 0, 0, 0);
        send(10'h237);
        chk_dec("d17_a7", 8'hF1, 0, 0, 0, 0, 1);
        send(10'h347);
        chk_dec("d11_a7bad", 8'h00, 0, 0, 1, 0, 1);
        send(10'h30B);
        chk_dec("k28_0p", 8'h1C, 1, 0, 0, 0, 1);

        // Wrong-RD comma: disp_err, FSM must stay in LOS
        do_reset("rst2");
        send(10'h305);
        chk_dec("k285_derr", 8'hBC, 1, 1, 0, 1, 0);
        check("derr.sync", sync_ok, 1'b0);
        send(10'h0FA);
        send(10'h305);
        check("derr_acq2.sync", sync_ok, 1'b0);
        send(10'h0FA);
        check("derr_acq3.sync", sync_ok, 1'b1);

        // Mid-stream reset with a group in flight, then restart from RD-
        @(negedge clk);
        rst      = 1'b1;
        rx_valid = 1'b1;
        rx_code  = 10'h2AA;
        @(posedge clk);
        #1;
        chk_reset("midrst");
        @(negedge clk);
        rst = 1'b0;
        send(10'h274);
        chk_dec("post_rst", 8'h00, 0, 0, 0, 0, 0);
        check("post_rst.sync", sync_ok, 1'b0);

        idle();
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
